// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction-fetch front end. Issues sequential fetch requests to instruction
// memory over a request/grant handshake, accepts in-order responses of
// variable latency, and buffers the returned instructions, each tagged with
// its PC + IpIncrement, in a Depth-entry FIFO that feeds the decode stage.
// A branch/jump redirect flushes the FIFO and silently discards responses
// that are still in flight for the abandoned path.
//
// Ports
//   Clk, Rst        : rising-edge clock, asynchronous active-low reset
//   InstAddr        : fetch address, valid whenever InstRead is high
//   InstRead        : fetch request
//   InstGnt         : memory accepts the request this cycle
//   InstValid       : in-order response valid
//   Instruction     : response data
//   Redirect        : branch/jump taken, highest priority
//   RedirectAddr    : new fetch target
//   Pop             : decode consumes the head entry
//   Valid_id        : head entry valid
//   Instruction_id  : head instruction
//   PcAdderOut_id   : head PC + IpIncrement
//   ProtoErr        : sticky, a response arrived with nothing outstanding
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int unsigned          DataWidth   = 32,
  parameter int unsigned          AddrWidth   = 32,
  parameter int unsigned          Depth       = 4,
  parameter int unsigned          IpIncrement = 4,
  parameter logic [AddrWidth-1:0] ResetVector = '0
) (
  input  logic                 Clk,
  input  logic                 Rst,
  output logic [AddrWidth-1:0] InstAddr,
  output logic                 InstRead,
  input  logic                 InstGnt,
  input  logic                 InstValid,
  input  logic [DataWidth-1:0] Instruction,
  input  logic                 Redirect,
  input  logic [AddrWidth-1:0] RedirectAddr,
  input  logic                 Pop,
  output logic                 Valid_id,
  output logic [DataWidth-1:0] Instruction_id,
  output logic [AddrWidth-1:0] PcAdderOut_id,
  output logic                 ProtoErr
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = $clog2(Depth);

  localparam logic [AddrWidth-1:0] PcStep      = AddrWidth'(IpIncrement);
  localparam logic [CntW:0]        CreditLimit = (CntW + 1)'(Depth);

  // Architectural state
  logic [AddrWidth-1:0] fetch_pc_q, fetch_pc_d;
  logic [AddrWidth-1:0] resp_pc_q, resp_pc_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [CntW-1:0]      outstanding_q, outstanding_d;
  logic [CntW-1:0]      drop_cnt_q, drop_cnt_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic                 proto_err_q, proto_err_d;

  // FIFO storage
  logic [DataWidth-1:0] inst_buf_q [Depth];
  logic [DataWidth-1:0] inst_buf_d [Depth];
  logic [AddrWidth-1:0] pc_buf_q   [Depth];
  logic [AddrWidth-1:0] pc_buf_d   [Depth];

  // Handshake decode
  logic [CntW:0] credit_sum;
  logic          inst_read;
  logic          grant;
  logic          resp_ok;
  logic          resp_err;
  logic          resp_drop;
  logic          push;
  logic          pop;
  logic          fifo_nonempty;

  // Credits are taken from registered Count and Outstanding only, so there
  // is no combinational path from Pop to InstRead. The request is held low
  // while reset is asserted even though the counters already read zero.
  assign credit_sum    = {1'b0, count_q} + {1'b0, outstanding_q};
  assign inst_read     = Rst && !Redirect && (credit_sum < CreditLimit);
  assign grant         = inst_read && InstGnt;
  assign fifo_nonempty = (count_q != '0);

  // A response with nothing outstanding is a protocol violation and is
  // otherwise ignored. Stale responses (DropCnt>0) are consumed but not
  // buffered. A redirect cancels any push or pop in its own cycle.
  assign resp_ok   = InstValid && (outstanding_q != '0);
  assign resp_err  = InstValid && (outstanding_q == '0);
  assign resp_drop = resp_ok && (drop_cnt_q != '0);
  assign push      = resp_ok && (drop_cnt_q == '0) && !Redirect;
  assign pop       = fifo_nonempty && Pop && !Redirect;

  assign InstRead       = inst_read;
  assign InstAddr       = fetch_pc_q;
  assign Valid_id       = fifo_nonempty;
  assign Instruction_id = inst_buf_q[rd_ptr_q];
  assign PcAdderOut_id  = pc_buf_q[rd_ptr_q];
  assign ProtoErr       = proto_err_q;

  // Next-state computation. Normal fetch/response/pop bookkeeping is done
  // first; a redirect then overrides the PCs, the FIFO and the drop count.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    count_d       = count_q;
    drop_cnt_d    = drop_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    proto_err_d   = proto_err_q | resp_err;
    inst_buf_d    = inst_buf_q;
    pc_buf_d      = pc_buf_q;
    outstanding_d = outstanding_q + CntW'(grant) - CntW'(resp_ok);

    if (grant) begin
      fetch_pc_d = fetch_pc_q + PcStep;
    end

    if (resp_drop) begin
      drop_cnt_d = drop_cnt_q - CntW'(1);
    end

    if (push) begin
      inst_buf_d[wr_ptr_q] = Instruction;
      pc_buf_d[wr_ptr_q]   = resp_pc_q + PcStep;
      wr_ptr_d             = wr_ptr_q + PtrW'(1);
      resp_pc_d            = resp_pc_q + PcStep;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    // Every request still outstanding after this cycle belongs to the
    // abandoned path, so the drop count is reloaded from Outstanding_next.
    // A grant cannot coincide because InstRead is forced low.
    if (Redirect) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = RedirectAddr;
      resp_pc_d  = RedirectAddr;
      drop_cnt_d = outstanding_d;
    end
  end

  // State and storage registers; reset clears the storage as well so the
  // head outputs read zero while in reset.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      fetch_pc_q    <= ResetVector;
      resp_pc_q     <= ResetVector;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      proto_err_q   <= 1'b0;
      inst_buf_q    <= '{default: '0};
      pc_buf_q      <= '{default: '0};
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      proto_err_q   <= proto_err_d;
      inst_buf_q    <= inst_buf_d;
      pc_buf_q      <= pc_buf_d;
    end
  end

endmodule
